// File: rtl/sysreg_perf_pkg.sv
// Shared register offsets, CTRL bit positions and bus FSM encodings for the sysreg_perf
// performance-counter bank.
package sysreg_perf_pkg;

    localparam logic [31:0] PERF_CTRL     = 32'h0000_0000;
    localparam logic [31:0] PERF_ENABLE   = 32'h0000_0004;
    localparam logic [31:0] PERF_OVF      = 32'h0000_0008;
    localparam logic [31:0] PERF_OVF_IE   = 32'h0000_000C;
    localparam logic [31:0] PERF_CNT_BASE = 32'h0000_0010;

    localparam int unsigned CTRL_EN     = 0;
    localparam int unsigned CTRL_FREEZE = 1;
    localparam int unsigned CTRL_CLR    = 2;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StDone  = 2'd2
    } bus_state_e;

endpackage

// File: rtl/perf_counter.sv
// Single CW-bit performance counter: clear, halfword-granular bus load, increment with wrap
// and a one-cycle overflow pulse on wrap.
module perf_counter
    import sysreg_perf_pkg::*;
#(
    parameter int unsigned CW = 48
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          wr_lo,
    input  logic          wr_hi,
    input  logic [1:0]    wen,
    input  logic [31:0]   wdata,
    input  logic          inc,
    output logic [CW-1:0] count,
    output logic          ovf
);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [63:0]   wide;

    always_comb begin
        wide = 64'(cnt_q);
        if (wr_lo) begin
            if (wen[0]) wide[15:0]  = wdata[15:0];
            if (wen[1]) wide[31:16] = wdata[31:16];
        end
        if (wr_hi) begin
            if (wen[0]) wide[47:32] = wdata[15:0];
            if (wen[1]) wide[63:48] = wdata[31:16];
        end
        cnt_d = cnt_q;
        ovf   = 1'b0;
        // A bus write to this counter swallows any increment in the same cycle.
        if (clr) begin
            cnt_d = '0;
        end else if (wr_lo || wr_hi) begin
            cnt_d = CW'(wide);
        end else if (inc) begin
            cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
            ovf   = &cnt_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count = cnt_q;

endmodule

// File: rtl/sysreg_perf.sv
// Performance-counter bank on the mgmt bus. Define SYSREG_PERF_SHADOW_EN for a shared HI
// shadow captured on CNT_LO reads, giving tear-free 64-bit read pairs.
module sysreg_perf
    import sysreg_perf_pkg::*;
#(
    parameter int unsigned NCNT  = 8,
    parameter int unsigned CW    = 48,
    parameter logic [31:0] BASE  = 32'h0000_0100,
    parameter logic [31:0] AMASK = 32'hFFFF_FF00
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            init,
    input  logic [NCNT-1:0] perf,
    output logic            irq,
    input  logic            mgmt_req,
    input  logic [31:0]     mgmt_adr,
    input  logic            mgmt_rwn,
    input  logic [1:0]      mgmt_wen,
    input  logic [31:0]     mgmt_txd,
    output logic            mgmt_ack,
    output logic            mgmt_rxe,
    output logic [31:0]     mgmt_rxd
);

    bus_state_e      st_q, st_d;
    logic [31:0]     adr_q, txd_q;
    logic            rwn_q;
    logic [1:0]      wen_q;
    logic            ack_q, rxe_q;
    logic [31:0]     rxd_q;

    logic            en_q, frz_q, irq_q;
    logic [NCNT-1:0] enable_q, ovf_q, ovf_ie_q, ovf_d;

    logic            hit, wr, rd;
    logic [31:0]     off, cnt_rel, cnt_idx;
    logic            in_cnt, is_hi, cnt_wr;
    logic            ctrl_wr, clr_all;
    logic [31:0]     rdata, sel_lo, sel_hi, hi_rd;

    logic [CW-1:0]   cnt    [NCNT];
    logic [31:0]     cnt_lo [NCNT];
    logic [31:0]     cnt_hi [NCNT];
    logic [NCNT-1:0] inc, wrap, wr_lo, wr_hi;

    // Bus FSM
    always_comb begin
        st_d = st_q;
        case (st_q)
            StIdle:  if (mgmt_req) st_d = StIssue;
            StIssue: st_d = StDone;
            StDone:  if (!mgmt_req) st_d = StIdle;
            default: st_d = StIdle;
        endcase
    end

    // Address decode of the captured request, valid only in the ISSUE cycle.
    assign off     = (adr_q & ~AMASK) & 32'hFFFF_FFFC;
    assign hit     = (st_q == StIssue) && ((adr_q & AMASK) == BASE);
    assign wr      = hit && !rwn_q;
    assign rd      = hit && rwn_q;
    assign cnt_rel = off - PERF_CNT_BASE;
    assign in_cnt  = (off >= PERF_CNT_BASE) && (cnt_rel < 32'(8 * NCNT));
    assign cnt_idx = cnt_rel >> 3;
    assign is_hi   = cnt_rel[2];
    assign cnt_wr  = wr && in_cnt;
    assign ctrl_wr = wr && (off == PERF_CTRL) && wen_q[0];
    assign clr_all = init || (ctrl_wr && txd_q[CTRL_CLR]);

    for (genvar i = 0; i < NCNT; i++) begin : g_cnt
        assign inc[i]   = perf[i] & enable_q[i] & en_q & ~frz_q;
        assign wr_lo[i] = cnt_wr && (cnt_idx == 32'(i)) && !is_hi;
        assign wr_hi[i] = cnt_wr && (cnt_idx == 32'(i)) && is_hi;

        perf_counter #(
            .CW(CW)
        ) u_cnt (
            .clk   (clk),
            .rst_n (rst_n),
            .clr   (clr_all),
            .wr_lo (wr_lo[i]),
            .wr_hi (wr_hi[i]),
            .wen   (wen_q),
            .wdata (txd_q),
            .inc   (inc[i]),
            .count (cnt[i]),
            .ovf   (wrap[i])
        );

        assign cnt_lo[i] = cnt[i][31:0];
        assign cnt_hi[i] = 32'(cnt[i] >> 32);
    end

`ifdef SYSREG_PERF_SHADOW_EN
    logic [31:0] shadow_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q <= '0;
        end else if (rd && in_cnt && !is_hi) begin
            shadow_q <= sel_hi;
        end
    end

    assign hi_rd = shadow_q;
`else
    assign hi_rd = sel_hi;
`endif

    always_comb begin
        sel_lo = '0;
        sel_hi = '0;
        for (int unsigned i = 0; i < NCNT; i++) begin
            if (cnt_idx == 32'(i)) begin
                sel_lo = cnt_lo[i];
                sel_hi = cnt_hi[i];
            end
        end
        rdata = '0;
        if (in_cnt) begin
            rdata = is_hi ? hi_rd : sel_lo;
        end else begin
            case (off)
                PERF_CTRL: begin
                    rdata[CTRL_EN]     = en_q;
                    rdata[CTRL_FREEZE] = frz_q;
                end
                PERF_ENABLE: rdata[NCNT-1:0] = enable_q;
                PERF_OVF:    rdata[NCNT-1:0] = ovf_q;
                PERF_OVF_IE: rdata[NCNT-1:0] = ovf_ie_q;
                default:     rdata = '0;
            endcase
        end
    end

    // A wrap in the same cycle wins over a W1C of that flag.
    always_comb begin
        ovf_d = ovf_q;
        if (wr && (off == PERF_OVF) && wen_q[0]) ovf_d = ovf_d & ~txd_q[NCNT-1:0];
        ovf_d = ovf_d | wrap;
        if (clr_all) ovf_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q  <= StIdle;
            adr_q <= '0;
            txd_q <= '0;
            rwn_q <= 1'b0;
            wen_q <= '0;
            ack_q <= 1'b0;
            rxe_q <= 1'b0;
            rxd_q <= '0;
        end else begin
            st_q <= st_d;
            if (st_q == StIdle && mgmt_req) begin
                adr_q <= mgmt_adr;
                txd_q <= mgmt_txd;
                rwn_q <= mgmt_rwn;
                wen_q <= mgmt_wen;
            end
            ack_q <= hit;
            rxe_q <= rd;
            rxd_q <= rd ? rdata : 32'h0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_q     <= 1'b0;
            frz_q    <= 1'b0;
            enable_q <= '1;
            ovf_q    <= '0;
            ovf_ie_q <= '0;
            irq_q    <= 1'b0;
        end else begin
            if (ctrl_wr) begin
                en_q  <= txd_q[CTRL_EN];
                frz_q <= txd_q[CTRL_FREEZE];
            end
            if (wr && (off == PERF_ENABLE) && wen_q[0]) enable_q <= txd_q[NCNT-1:0];
            if (wr && (off == PERF_OVF_IE) && wen_q[0]) ovf_ie_q <= txd_q[NCNT-1:0];
            ovf_q <= ovf_d;
            irq_q <= |(ovf_q & ovf_ie_q);
        end
    end

    assign irq      = irq_q;
    assign mgmt_ack = ack_q;
    assign mgmt_rxe = rxe_q;
    assign mgmt_rxd = rxd_q;

endmodule

// File: tb/tb_sysreg_perf.sv
// Self-checking bench for sysreg_perf: directed cases plus randomized bus/strobe traffic,
// checked every cycle against a behavioural model of the counter bank.
module tb_sysreg_perf;

    localparam int NCNT = 8;
    localparam int CW   = 48;
    localparam logic [31:0] BASE  = 32'h0000_0100;
    localparam logic [31:0] AMASK = 32'hFFFF_FF00;
    localparam longint unsigned MAXV = 64'h0000_FFFF_FFFF_FFFF;
`ifdef SYSREG_PERF_SHADOW_EN
    localparam bit SHADOW = 1'b1;
`else
    localparam bit SHADOW = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            init = 1'b0;
    logic [NCNT-1:0] perf = '0;
    logic            irq;
    logic            mgmt_req = 1'b0;
    logic [31:0]     mgmt_adr = '0;
    logic            mgmt_rwn = 1'b1;
    logic [1:0]      mgmt_wen = '0;
    logic [31:0]     mgmt_txd = '0;
    logic            mgmt_ack, mgmt_rxe;
    logic [31:0]     mgmt_rxd;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sysreg_perf #(
        .NCNT (NCNT),
        .CW   (CW),
        .BASE (BASE),
        .AMASK(AMASK)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .init     (init),
        .perf     (perf),
        .irq      (irq),
        .mgmt_req (mgmt_req),
        .mgmt_adr (mgmt_adr),
        .mgmt_rwn (mgmt_rwn),
        .mgmt_wen (mgmt_wen),
        .mgmt_txd (mgmt_txd),
        .mgmt_ack (mgmt_ack),
        .mgmt_rxe (mgmt_rxe),
        .mgmt_rxd (mgmt_rxd)
    );

    // Behavioural model state
    longint unsigned m_cnt [NCNT];
    logic            m_en, m_frz;
    logic [NCNT-1:0] m_enable, m_ovf, m_ie;
    logic [31:0]     m_shadow, m_adr, m_txd;
    logic            m_rwn;
    logic [1:0]      m_wen;
    int              m_ph;
    logic            e_irq, e_ack, e_rxe;
    logic [31:0]     e_rxd;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NCNT; i++) m_cnt[i] = 0;
        m_en = 0; m_frz = 0; m_enable = '1; m_ovf = '0; m_ie = '0; m_shadow = '0;
        m_ph = 0; m_adr = '0; m_txd = '0; m_rwn = 1'b0; m_wen = '0;
        e_irq = 0; e_ack = 0; e_rxe = 0; e_rxd = '0;
    endtask

    function automatic longint unsigned apply(input longint unsigned v, input logic hi,
                                              input logic [1:0] wen, input logic [31:0] d);
        longint unsigned r = v;
        int sh = hi ? 32 : 0;
        if (wen[0]) r = (r & ~(64'hFFFF << sh)) | (64'(d[15:0]) << sh);
        if (wen[1]) r = (r & ~(64'hFFFF << (sh + 16))) | (64'(d[31:16]) << (sh + 16));
        return r & MAXV;
    endfunction

    // One clock edge of the register bank, using the inputs present at that edge.
    task automatic model_edge();
        logic [NCNT-1:0] inc, wraps, w1c;
        logic            clr_all, hit, rd, wr, in_cnt, is_hi;
        logic [31:0]     off, rval;
        int              idx;
        if (!rst_n) begin
            model_reset();
            return;
        end
        e_irq  = |(m_ovf & m_ie);
        inc    = (m_en && !m_frz) ? (perf & m_enable) : '0;
        hit    = (m_ph == 1) && ((m_adr & AMASK) == BASE);
        rd     = hit && m_rwn;
        wr     = hit && !m_rwn;
        off    = m_adr & 32'h0000_00FC;
        in_cnt = (off >= 16) && (off < 16 + 8 * NCNT);
        idx    = in_cnt ? int'((off - 32'd16) >> 3) : 0;
        is_hi  = in_cnt && (((off - 32'd16) % 8) == 4);
        rval   = '0;
        if (rd) begin
            if (in_cnt) begin
                if (is_hi) rval = SHADOW ? m_shadow : 32'(m_cnt[idx] >> 32);
                else       rval = 32'(m_cnt[idx]);
            end else begin
                case (off)
                    32'h0:   rval = {30'b0, m_frz, m_en};
                    32'h4:   rval = 32'(m_enable);
                    32'h8:   rval = 32'(m_ovf);
                    32'hC:   rval = 32'(m_ie);
                    default: rval = '0;
                endcase
            end
            if (in_cnt && !is_hi) m_shadow = 32'(m_cnt[idx] >> 32);
        end
        clr_all = init;
        w1c = '0;
        if (wr && m_wen[0]) begin
            case (off)
                32'h0: begin m_en = m_txd[0]; m_frz = m_txd[1]; clr_all = clr_all | m_txd[2]; end
                32'h4:   m_enable = m_txd[NCNT-1:0];
                32'h8:   w1c = m_txd[NCNT-1:0];
                32'hC:   m_ie = m_txd[NCNT-1:0];
                default: ;
            endcase
        end
        wraps = '0;
        for (int i = 0; i < NCNT; i++) begin
            if (clr_all) m_cnt[i] = 0;
            else if (wr && in_cnt && idx == i) m_cnt[i] = apply(m_cnt[i], is_hi, m_wen, m_txd);
            else if (inc[i]) begin
                if (m_cnt[i] == MAXV) begin m_cnt[i] = 0; wraps[i] = 1'b1; end
                else m_cnt[i] = m_cnt[i] + 1;
            end
        end
        m_ovf = clr_all ? '0 : ((m_ovf & ~w1c) | wraps);
        e_ack = 0; e_rxe = 0; e_rxd = '0;
        case (m_ph)
            0: if (mgmt_req) begin
                m_ph = 1; m_adr = mgmt_adr; m_txd = mgmt_txd; m_rwn = mgmt_rwn; m_wen = mgmt_wen;
            end
            1: begin e_ack = hit; e_rxe = rd; e_rxd = rval; m_ph = 2; end
            default: if (!mgmt_req) m_ph = 0;
        endcase
    endtask

    always @(posedge clk) begin
        model_edge();
        #1;
        check("irq", irq, e_irq);
        check("ack", mgmt_ack, e_ack);
        check("rxe", mgmt_rxe, e_rxe);
        check("rxd", mgmt_rxd, e_rxd);
    end

    // One bus transaction; ip is driven on perf during the cycle the access happens.
    task automatic bus(input logic rwn, input logic [31:0] adr, input logic [1:0] wen,
                       input logic [31:0] txd, input logic [NCNT-1:0] ip,
                       output logic [31:0] rd, output int lat);
        bit got = 0;
        @(negedge clk);
        mgmt_req = 1'b1; mgmt_rwn = rwn; mgmt_adr = adr; mgmt_wen = wen; mgmt_txd = txd;
        lat = 0; rd = '0;
        for (int k = 1; k <= 6 && !got; k++) begin
            @(posedge clk);
            #1;
            if (mgmt_ack) begin got = 1; lat = k; rd = mgmt_rxd; end
            @(negedge clk);
            perf = (k == 1) ? ip : '0;
        end
        mgmt_req = 1'b0;
        perf = '0;
    endtask

    task automatic rdc(input string name, input logic [31:0] adr, input logic [31:0] exp);
        logic [31:0] rd;
        int lat;
        bus(1'b1, adr, 2'b00, 32'h0, '0, rd, lat);
        check(name, rd, exp);
        check({name, "_lat"}, lat, 2);
    endtask

    task automatic wrc(input logic [31:0] adr, input logic [1:0] wen, input logic [31:0] txd,
                       input logic [NCNT-1:0] ip);
        logic [31:0] rd;
        int lat;
        bus(1'b0, adr, wen, txd, ip, rd, lat);
        check("wr_lat", lat, 2);
    endtask

    task automatic strobe(input logic [NCNT-1:0] mask, input int n);
        repeat (n) begin
            @(negedge clk);
            perf = mask;
        end
        @(negedge clk);
        perf = '0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout at %0t", $time);
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        int lat;
        logic [31:0] adr, txd;
        logic [1:0] wen;
        logic rwn;
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check("rst_irq", irq, 0);

        rdc("enable_rst", 32'h104, 32'h0000_00FF);

        wrc(32'h100, 2'b11, 32'h1, '0);
        strobe(8'h08, 10);
        rdc("cnt3_10", 32'h128, 32'd10);
        wrc(32'h100, 2'b11, 32'h3, '0);
        strobe(8'h08, 5);
        rdc("cnt3_frozen", 32'h128, 32'd10);
        rdc("ctrl_rd", 32'h100, 32'h3);
        wrc(32'h100, 2'b11, 32'h1, '0);

        wrc(32'h110, 2'b11, 32'hFFFF_FFFE, '0);
        wrc(32'h114, 2'b11, 32'h0000_FFFF, '0);
        wrc(32'h10C, 2'b11, 32'h1, '0);
        strobe(8'h01, 2);
        rdc("cnt0_lo_wrap", 32'h110, 32'h0);
        rdc("cnt0_hi_wrap", 32'h114, 32'h0);
        rdc("ovf_wrap", 32'h108, 32'h1);
        check("irq_ovf", irq, 1);
        wrc(32'h108, 2'b01, 32'h1, '0);
        @(posedge clk);
        #1;
        check("irq_clr", irq, 0);

        wrc(32'h120, 2'b11, 32'h55, 8'h04);
        rdc("cnt2_wr_beats_inc", 32'h120, 32'h55);
        wrc(32'h118, 2'b11, 32'hFFFF_FFFF, '0);
        wrc(32'h11C, 2'b11, 32'h0000_FFFF, '0);
        strobe(8'h02, 1);
        rdc("ovf_cnt1", 32'h108, 32'h2);
        @(negedge clk);
        init = 1'b1; perf = '1;
        @(negedge clk);
        init = 1'b0; perf = '0;
        for (int i = 0; i < NCNT; i++) rdc("init_cnt", 32'h110 + 32'(8 * i), 32'h0);
        rdc("init_ovf", 32'h108, 32'h0);

        wrc(32'h130, 2'b11, 32'hFFFF_FFFF, '0);
        wrc(32'h134, 2'b11, 32'h0000_0001, '0);
        rdc("shadow_lo", 32'h130, 32'hFFFF_FFFF);
        strobe(8'h10, 1);
        rdc("shadow_hi", 32'h134, SHADOW ? 32'h1 : 32'h2);

        bus(1'b1, 32'h200, 2'b00, 32'h0, '0, rd, lat);
        check("miss_noack", lat, 0);
        rdc("after_miss", 32'h104, 32'h0000_00FF);

        wrc(32'h104, 2'b11, 32'h0F, '0);
        @(negedge clk);
        mgmt_req = 1'b1; mgmt_rwn = 1'b1; mgmt_adr = 32'h104;
        @(posedge clk);
        #1;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_mid_ack", mgmt_ack, 0);
        @(negedge clk);
        rst_n = 1'b1; mgmt_req = 1'b0;
        rdc("after_rst_enable", 32'h104, 32'h0000_00FF);

        for (int t = 0; t < 80; t++) begin
            repeat ($urandom_range(0, 3)) begin
                @(negedge clk);
                perf = NCNT'($urandom);
                init = ($urandom_range(0, 40) == 0);
            end
            @(negedge clk);
            perf = '0; init = 1'b0;
            if ($urandom_range(0, 9) == 0) adr = 32'h200 + 32'($urandom_range(0, 255));
            else adr = 32'h100 + 32'($urandom_range(0, 23) * 4) + 32'($urandom_range(0, 3));
            rwn = 1'($urandom);
            wen = 2'($urandom);
            txd = $urandom;
            case (adr & 32'hFFFF_FFFC)
                32'h100: txd = {txd[31:3], ($urandom_range(0, 9) == 0), ($urandom_range(0, 4) == 0), 1'b1};
                32'h110, 32'h118, 32'h120, 32'h128, 32'h130, 32'h138, 32'h140, 32'h148:
                    txd = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
                32'h114, 32'h11C, 32'h124, 32'h12C, 32'h134, 32'h13C, 32'h144, 32'h14C:
                    txd = 32'h0000_FFFF;
                default: ;
            endcase
            bus(rwn, adr, wen, txd, NCNT'($urandom), rd, lat);
            check("rnd_lat", lat, ((adr & AMASK) == BASE) ? 2 : 0);
        end

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
